// File: rtl/counter_cmd_pkg.sv
// Shared types for the counter command sequencer: opcodes, FSM states, defaults.
// ctrl_of() maps an opcode to its one-hot {load, hold, count_up, count_down} pattern.
package counter_cmd_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 4;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_HOLD = 2'b01,
        OP_UP   = 2'b10,
        OP_DOWN = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    function automatic logic [3:0] ctrl_of(input op_e op);
        logic [3:0] r;
        r = 4'b0000;
        case (op)
            OP_LOAD: r = 4'b1000;
            OP_HOLD: r = 4'b0100;
            OP_UP:   r = 4'b0010;
            OP_DOWN: r = 4'b0001;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/counter_cmd_seq_if.sv
// Command handshake into the sequencer: opcode + argument over valid/ready.
// master drives the command, slave (the sequencer) returns ready.
interface counter_cmd_seq_if
    import counter_cmd_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    op_e              cmd_op;
    logic [WIDTH-1:0] cmd_arg;

    modport master (output cmd_valid, output cmd_op, output cmd_arg, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_op, input  cmd_arg, output cmd_ready);
endinterface

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with flush; head is read combinationally, push/pop take effect at the edge.
// Push is ignored while full and pop while empty, so callers may gate loosely.
module cmd_fifo #(
    parameter  int DEPTH = 4,
    parameter  int DW    = 6,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] pop_dat,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push_ok, pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/counter_cmd_seq.sv
// Replays queued counter commands as registered one-hot controls; first controls appear one cycle after the pop.
// cmd_ready drops when the FIFO is full or during flush; commands run back-to-back with no idle cycle.
module counter_cmd_seq
    import counter_cmd_pkg::*;
#(
    parameter  int DEPTH = DEF_DEPTH,
    parameter  int WIDTH = DEF_WIDTH,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    counter_cmd_seq_if.slave cmd,
    output logic             load,
    output logic             hold,
    output logic             count_up,
    output logic             count_down,
    output logic             En,
    output logic [WIDTH-1:0] initial_value,
    output logic             busy,
    output logic [CW-1:0]    fifo_count
);
    state_e           state, state_nxt;
    logic [WIDTH-1:0] remain, remain_nxt;
    logic [WIDTH-1:0] iv_q, iv_nxt;
    logic [3:0]       ctrl_q, ctrl_nxt;
    logic             en_q, en_nxt;
    logic             fifo_full, fifo_empty, push, pop;
    logic [WIDTH+1:0] head;
    op_e              hd_op;
    logic [WIDTH-1:0] hd_arg;

    assign cmd.cmd_ready = !fifo_full && !flush;
    assign push          = cmd.cmd_valid && cmd.cmd_ready;

    cmd_fifo #(.DEPTH(DEPTH), .DW(WIDTH + 2)) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .push     (push),
        .push_dat ({cmd.cmd_op, cmd.cmd_arg}),
        .pop      (pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign hd_op  = op_e'(head[WIDTH+1:WIDTH]);
    assign hd_arg = head[WIDTH-1:0];

    // remain is always 0 in IDLE, so "remain == 0" uniformly means "ready for the next command".
    always_comb begin
        state_nxt  = state;
        remain_nxt = remain;
        iv_nxt     = iv_q;
        ctrl_nxt   = ctrl_q;
        en_nxt     = en_q;
        pop        = 1'b0;
        if (flush) begin
            state_nxt  = ST_IDLE;
            remain_nxt = '0;
            ctrl_nxt   = '0;
            en_nxt     = 1'b0;
        end else if (state == ST_ISSUE && remain != '0) begin
            remain_nxt = remain - WIDTH'(1);
        end else if (!fifo_empty) begin
            pop        = 1'b1;
            state_nxt  = ST_ISSUE;
            en_nxt     = 1'b1;
            ctrl_nxt   = ctrl_of(hd_op);
            remain_nxt = (hd_op == OP_LOAD) ? '0 : hd_arg;
            if (hd_op == OP_LOAD) iv_nxt = hd_arg;
        end else begin
            state_nxt = ST_IDLE;
            ctrl_nxt  = '0;
            en_nxt    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            remain <= '0;
            iv_q   <= '0;
            ctrl_q <= '0;
            en_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            remain <= remain_nxt;
            iv_q   <= iv_nxt;
            ctrl_q <= ctrl_nxt;
            en_q   <= en_nxt;
        end
    end

    assign {load, hold, count_up, count_down} = ctrl_q;
    assign En            = en_q;
    assign initial_value = iv_q;
    assign busy          = (state == ST_ISSUE);

endmodule
